// File: rtl/alu_arbiter.sv
// Two-requester front end for one shared 32-bit ALU. It arbitrates, registers the operands,
// executes for one cycle, then holds a tagged result until the consumer takes it.
module alu_arbiter #(
  parameter bit FIXED_PRIO = 1'b0,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             r0_valid,
  output logic             r0_ready,
  input  logic [1:0]       r0_op,
  input  logic [31:0]      r0_a,
  input  logic [31:0]      r0_b,
  input  logic             r1_valid,
  output logic             r1_ready,
  input  logic [1:0]       r1_op,
  input  logic [31:0]      r1_a,
  input  logic [31:0]      r1_b,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_tag,
  output logic [31:0]      resp_result,
  output logic [3:0]       resp_flags,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  // state | meaning
  // IDLE  | waiting for a request; the only state in which a requester can be granted
  // EXEC  | ALU evaluates the registered operands; result captured at the end
  // RESP  | registered result held until resp_ready
  typedef enum logic [1:0] {IDLE, EXEC, RESP} stateT;

  stateT       state, nextState;
  logic        lastGrant, ownerReg;
  logic [1:0]  opReg;
  logic [31:0] aReg, bReg;
  logic        grant0, grant1, accept0, accept1;

  logic [31:0] bMod, sum, aluResult;
  logic        subtract, carryOut, overflow;
  logic [3:0]  aluFlags;

  // On a tie in round-robin mode, r1 wins only when r0 was the last requester granted.
  always_comb begin
    grant1   = r1_valid && (!r0_valid || (FIXED_PRIO == 1'b0 && lastGrant == 1'b0));
    grant0   = r0_valid && !grant1;
    r0_ready = (state == IDLE) && grant0;
    r1_ready = (state == IDLE) && grant1;
    accept0  = r0_valid && r0_ready;
    accept1  = r1_valid && r1_ready;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (accept0 || accept1) nextState = EXEC;
      EXEC:    nextState = RESP;
      RESP:    if (resp_ready) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= nextState;
  end

  // The shared ALU: one adder serves add/sub/slt, and its carry and overflow appear in the flags for every op.
  always_comb begin
    subtract             = opReg[1];
    bMod                 = subtract ? ~bReg : bReg;
    {carryOut, sum}      = {1'b0, aReg} + {1'b0, bMod} + {32'd0, subtract};
    overflow             = (aReg[31] == bMod[31]) && (sum[31] != aReg[31]);
    case (opReg)
      2'b00:   aluResult = sum;
      2'b01:   aluResult = aReg ^ bReg;
      2'b10:   aluResult = sum;
      default: aluResult = {31'd0, sum[31] ^ overflow};
    endcase
    aluFlags = {carryOut, overflow, aluResult[31], aluResult == 32'd0};
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      opReg       <= 2'b00;
      aReg        <= 32'd0;
      bReg        <= 32'd0;
      ownerReg    <= 1'b0;
      lastGrant   <= 1'b1;
      resp_valid  <= 1'b0;
      resp_tag    <= 1'b0;
      resp_result <= 32'd0;
      resp_flags  <= 4'd0;
      op_count    <= '0;
    end else begin
      if (accept0 || accept1) begin
        opReg     <= accept1 ? r1_op : r0_op;
        aReg      <= accept1 ? r1_a  : r0_a;
        bReg      <= accept1 ? r1_b  : r0_b;
        ownerReg  <= accept1;
        lastGrant <= accept1;
      end
      if (state == EXEC) begin
        resp_result <= aluResult;
        resp_flags  <= aluFlags;
        resp_tag    <= ownerReg;
        resp_valid  <= 1'b1;
      end
      if (state == RESP && resp_ready) begin
        resp_valid <= 1'b0;
        if (op_count != '1) op_count <= op_count + CNT_W'(1);
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: instance 0 is round-robin, 1 is fixed priority, 2 has a 2-bit counter.
module tb_alu_arbiter;

  logic        clk;
  logic        resetN;
  logic        r0Valid [3];
  logic        r1Valid [3];
  logic        r0Ready [3];
  logic        r1Ready [3];
  logic [1:0]  r0Op [3];
  logic [1:0]  r1Op [3];
  logic [31:0] r0A [3];
  logic [31:0] r0B [3];
  logic [31:0] r1A [3];
  logic [31:0] r1B [3];
  logic        respValid [3];
  logic        respReady [3];
  logic        respTag [3];
  logic [31:0] respResult [3];
  logic [3:0]  respFlags [3];
  logic        busy [3];
  logic [15:0] opCountA, opCountB;
  logic [1:0]  opCountC;

  int checks = 0;
  int errors = 0;

  alu_arbiter #(.FIXED_PRIO(1'b0), .CNT_W(16)) dutRr (
    .clk(clk), .reset_n(resetN),
    .r0_valid(r0Valid[0]), .r0_ready(r0Ready[0]), .r0_op(r0Op[0]), .r0_a(r0A[0]), .r0_b(r0B[0]),
    .r1_valid(r1Valid[0]), .r1_ready(r1Ready[0]), .r1_op(r1Op[0]), .r1_a(r1A[0]), .r1_b(r1B[0]),
    .resp_valid(respValid[0]), .resp_ready(respReady[0]), .resp_tag(respTag[0]),
    .resp_result(respResult[0]), .resp_flags(respFlags[0]), .busy(busy[0]), .op_count(opCountA));

  alu_arbiter #(.FIXED_PRIO(1'b1), .CNT_W(16)) dutFix (
    .clk(clk), .reset_n(resetN),
    .r0_valid(r0Valid[1]), .r0_ready(r0Ready[1]), .r0_op(r0Op[1]), .r0_a(r0A[1]), .r0_b(r0B[1]),
    .r1_valid(r1Valid[1]), .r1_ready(r1Ready[1]), .r1_op(r1Op[1]), .r1_a(r1A[1]), .r1_b(r1B[1]),
    .resp_valid(respValid[1]), .resp_ready(respReady[1]), .resp_tag(respTag[1]),
    .resp_result(respResult[1]), .resp_flags(respFlags[1]), .busy(busy[1]), .op_count(opCountB));

  alu_arbiter #(.FIXED_PRIO(1'b0), .CNT_W(2)) dutSat (
    .clk(clk), .reset_n(resetN),
    .r0_valid(r0Valid[2]), .r0_ready(r0Ready[2]), .r0_op(r0Op[2]), .r0_a(r0A[2]), .r0_b(r0B[2]),
    .r1_valid(r1Valid[2]), .r1_ready(r1Ready[2]), .r1_op(r1Op[2]), .r1_a(r1A[2]), .r1_b(r1B[2]),
    .resp_valid(respValid[2]), .resp_ready(respReady[2]), .resp_tag(respTag[2]),
    .resp_result(respResult[2]), .resp_flags(respFlags[2]), .busy(busy[2]), .op_count(opCountC));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    tick();
    tick();
    resetN = 1'b1;
    #1;
    checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy[0]); end
    checks++; if (respValid[0] !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got %0b want 0", respValid[0]); end
    checks++; if (respTag[0] !== 1'b0) begin errors++; $display("FAIL reset_tag got %0b want 0", respTag[0]); end
    checks++; if (respResult[0] !== 32'd0) begin errors++; $display("FAIL reset_result got %h want 00000000", respResult[0]); end
    checks++; if (respFlags[0] !== 4'd0) begin errors++; $display("FAIL reset_flags got %b want 0000", respFlags[0]); end
    checks++; if (opCountA !== 16'd0) begin errors++; $display("FAIL reset_count got %0d want 0", opCountA); end
    checks++; if (opCountC !== 2'd0) begin errors++; $display("FAIL reset_count_sat got %0d want 0", opCountC); end
    checks++; if (r0Ready[0] !== 1'b0) begin errors++; $display("FAIL reset_r0_ready_idle got %0b want 0", r0Ready[0]); end
  endtask

  task automatic test_single();
    r0Valid[0] = 1'b1; r0Op[0] = 2'b00; r0A[0] = 32'd0; r0B[0] = 32'd1; respReady[0] = 1'b1;
    #1;
    checks++; if (r0Ready[0] !== 1'b1) begin errors++; $display("FAIL single_r0_ready got %0b want 1", r0Ready[0]); end
    checks++; if (r1Ready[0] !== 1'b0) begin errors++; $display("FAIL single_r1_ready got %0b want 0", r1Ready[0]); end
    tick();
    r0Valid[0] = 1'b0;
    #1;
    checks++; if (busy[0] !== 1'b1) begin errors++; $display("FAIL single_busy_exec got %0b want 1", busy[0]); end
    checks++; if (respValid[0] !== 1'b0) begin errors++; $display("FAIL single_valid_exec got %0b want 0", respValid[0]); end
    checks++; if (r0Ready[0] !== 1'b0) begin errors++; $display("FAIL single_ready_exec got %0b want 0", r0Ready[0]); end
    tick();
    checks++; if (respValid[0] !== 1'b1) begin errors++; $display("FAIL single_valid got %0b want 1", respValid[0]); end
    checks++; if (respResult[0] !== 32'd1) begin errors++; $display("FAIL single_result got %h want 00000001", respResult[0]); end
    checks++; if (respFlags[0] !== 4'b0000) begin errors++; $display("FAIL single_flags got %b want 0000", respFlags[0]); end
    checks++; if (respTag[0] !== 1'b0) begin errors++; $display("FAIL single_tag got %0b want 0", respTag[0]); end
    tick();
    checks++; if (respValid[0] !== 1'b0) begin errors++; $display("FAIL single_valid_done got %0b want 0", respValid[0]); end
    checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL single_busy_done got %0b want 0", busy[0]); end
    checks++; if (opCountA !== 16'd1) begin errors++; $display("FAIL single_count got %0d want 1", opCountA); end
  endtask

  task automatic test_round_robin();
    resetN = 1'b0;
    tick();
    resetN = 1'b1;
    r0Valid[0] = 1'b1; r0Op[0] = 2'b10; r0A[0] = 32'd0; r0B[0] = 32'd1;
    r1Valid[0] = 1'b1; r1Op[0] = 2'b11; r1A[0] = 32'd0; r1B[0] = 32'd1;
    respReady[0] = 1'b1;
    #1;
    checks++; if (r0Ready[0] !== 1'b1) begin errors++; $display("FAIL rr_first_r0_ready got %0b want 1", r0Ready[0]); end
    checks++; if (r1Ready[0] !== 1'b0) begin errors++; $display("FAIL rr_first_r1_ready got %0b want 0", r1Ready[0]); end
    tick();
    r0Valid[0] = 1'b0;
    #1;
    checks++; if (r1Ready[0] !== 1'b0) begin errors++; $display("FAIL rr_r1_ready_exec got %0b want 0", r1Ready[0]); end
    tick();
    checks++; if (respResult[0] !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rr_sub_result got %h want ffffffff", respResult[0]); end
    checks++; if (respFlags[0] !== 4'b0010) begin errors++; $display("FAIL rr_sub_flags got %b want 0010", respFlags[0]); end
    checks++; if (respTag[0] !== 1'b0) begin errors++; $display("FAIL rr_sub_tag got %0b want 0", respTag[0]); end
    tick();
    checks++; if (r1Ready[0] !== 1'b1) begin errors++; $display("FAIL rr_second_r1_ready got %0b want 1", r1Ready[0]); end
    tick();
    r1Valid[0] = 1'b0;
    tick();
    checks++; if (respResult[0] !== 32'd1) begin errors++; $display("FAIL rr_slt_result got %h want 00000001", respResult[0]); end
    checks++; if (respFlags[0] !== 4'b0000) begin errors++; $display("FAIL rr_slt_flags got %b want 0000", respFlags[0]); end
    checks++; if (respTag[0] !== 1'b1) begin errors++; $display("FAIL rr_slt_tag got %0b want 1", respTag[0]); end
    tick();
    r0Valid[0] = 1'b1; r0Op[0] = 2'b00; r0A[0] = 32'd1; r0B[0] = 32'd1;
    r1Valid[0] = 1'b1; r1Op[0] = 2'b00; r1A[0] = 32'd2; r1B[0] = 32'd2;
    #1;
    checks++; if (r0Ready[0] !== 1'b1) begin errors++; $display("FAIL rr_third_r0_ready got %0b want 1", r0Ready[0]); end
    checks++; if (r1Ready[0] !== 1'b0) begin errors++; $display("FAIL rr_third_r1_ready got %0b want 0", r1Ready[0]); end
    tick();
    r0Valid[0] = 1'b0;
    tick();
    checks++; if (respResult[0] !== 32'd2) begin errors++; $display("FAIL rr_third_result got %h want 00000002", respResult[0]); end
    tick();
    checks++; if (r1Ready[0] !== 1'b1) begin errors++; $display("FAIL rr_fourth_r1_ready got %0b want 1", r1Ready[0]); end
    tick();
    r1Valid[0] = 1'b0;
    tick();
    checks++; if (respTag[0] !== 1'b1) begin errors++; $display("FAIL rr_fourth_tag got %0b want 1", respTag[0]); end
    checks++; if (respResult[0] !== 32'd4) begin errors++; $display("FAIL rr_fourth_result got %h want 00000004", respResult[0]); end
    tick();
  endtask

  task automatic test_fixed_prio();
    respReady[1] = 1'b1;
    r1Valid[1] = 1'b1; r1Op[1] = 2'b00; r1A[1] = 32'd7; r1B[1] = 32'd7;
    r0Valid[1] = 1'b1; r0Op[1] = 2'b00; r0A[1] = 32'd10; r0B[1] = 32'd0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (r0Ready[1] !== 1'b1) begin errors++; $display("FAIL fix_r0_ready_%0d got %0b want 1", i, r0Ready[1]); end
      checks++; if (r1Ready[1] !== 1'b0) begin errors++; $display("FAIL fix_r1_ready_idle_%0d got %0b want 0", i, r1Ready[1]); end
      tick();
      r0B[1] = 32'(i + 1);
      #1;
      checks++; if (r1Ready[1] !== 1'b0) begin errors++; $display("FAIL fix_r1_ready_exec_%0d got %0b want 0", i, r1Ready[1]); end
      tick();
      checks++; if (respTag[1] !== 1'b0) begin errors++; $display("FAIL fix_tag_%0d got %0b want 0", i, respTag[1]); end
      checks++; if (respResult[1] !== 32'(10 + i)) begin errors++; $display("FAIL fix_result_%0d got %0d want %0d", i, respResult[1], 10 + i); end
      tick();
    end
    r0Valid[1] = 1'b0;
    r1Valid[1] = 1'b0;
    #1;
    checks++; if (opCountB !== 16'd3) begin errors++; $display("FAIL fix_count got %0d want 3", opCountB); end
  endtask

  task automatic test_stall();
    respReady[0] = 1'b0;
    r1Valid[0] = 1'b1; r1Op[0] = 2'b00; r1A[0] = 32'h8000_0000; r1B[0] = 32'h8000_0000;
    #1;
    checks++; if (r1Ready[0] !== 1'b1) begin errors++; $display("FAIL stall_r1_ready got %0b want 1", r1Ready[0]); end
    tick();
    r1Valid[0] = 1'b0;
    r0Valid[0] = 1'b1; r0Op[0] = 2'b00; r0A[0] = 32'd2; r0B[0] = 32'd3;
    tick();
    for (int i = 0; i < 5; i++) begin
      checks++; if (respValid[0] !== 1'b1) begin errors++; $display("FAIL stall_valid_%0d got %0b want 1", i, respValid[0]); end
      checks++; if (respResult[0] !== 32'd0) begin errors++; $display("FAIL stall_result_%0d got %h want 00000000", i, respResult[0]); end
      checks++; if (respFlags[0] !== 4'b1101) begin errors++; $display("FAIL stall_flags_%0d got %b want 1101", i, respFlags[0]); end
      checks++; if (respTag[0] !== 1'b1) begin errors++; $display("FAIL stall_tag_%0d got %0b want 1", i, respTag[0]); end
      checks++; if (r0Ready[0] !== 1'b0) begin errors++; $display("FAIL stall_r0_ready_%0d got %0b want 0", i, r0Ready[0]); end
      tick();
    end
    respReady[0] = 1'b1;
    tick();
    checks++; if (respValid[0] !== 1'b0) begin errors++; $display("FAIL stall_release_valid got %0b want 0", respValid[0]); end
    checks++; if (r0Ready[0] !== 1'b1) begin errors++; $display("FAIL stall_release_r0_ready got %0b want 1", r0Ready[0]); end
    tick();
    r0Valid[0] = 1'b0;
    tick();
    checks++; if (respResult[0] !== 32'd5) begin errors++; $display("FAIL stall_next_result got %h want 00000005", respResult[0]); end
    checks++; if (respTag[0] !== 1'b0) begin errors++; $display("FAIL stall_next_tag got %0b want 0", respTag[0]); end
    tick();
    checks++; if (opCountA !== 16'd6) begin errors++; $display("FAIL stall_count got %0d want 6", opCountA); end
  endtask

  task automatic test_reset_exec();
    respReady[0] = 1'b1;
    r0Valid[0] = 1'b1; r0Op[0] = 2'b01; r0A[0] = 32'hF0F0_F0F0; r0B[0] = 32'h0F0F_0F0F;
    #1;
    checks++; if (r0Ready[0] !== 1'b1) begin errors++; $display("FAIL rexec_r0_ready got %0b want 1", r0Ready[0]); end
    tick();
    r0Valid[0] = 1'b0;
    #1;
    checks++; if (busy[0] !== 1'b1) begin errors++; $display("FAIL rexec_busy got %0b want 1", busy[0]); end
    resetN = 1'b0;
    tick();
    resetN = 1'b1;
    #1;
    checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL rexec_idle got %0b want 0", busy[0]); end
    checks++; if (respValid[0] !== 1'b0) begin errors++; $display("FAIL rexec_valid got %0b want 0", respValid[0]); end
    checks++; if (opCountA !== 16'd0) begin errors++; $display("FAIL rexec_count got %0d want 0", opCountA); end
    tick();
    checks++; if (respValid[0] !== 1'b0) begin errors++; $display("FAIL rexec_no_resp got %0b want 0", respValid[0]); end
    r0Valid[0] = 1'b1;
    #1;
    tick();
    r0Valid[0] = 1'b0;
    tick();
    checks++; if (respValid[0] !== 1'b1) begin errors++; $display("FAIL rexec_reissue_valid got %0b want 1", respValid[0]); end
    checks++; if (respResult[0] !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rexec_reissue_result got %h want ffffffff", respResult[0]); end
    checks++; if (respFlags[0][1] !== 1'b1) begin errors++; $display("FAIL rexec_reissue_negative got %0b want 1", respFlags[0][1]); end
    tick();
  endtask

  task automatic test_sat_count();
    logic [1:0] expCnt [5];
    expCnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    respReady[2] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      r0Valid[2] = 1'b1; r0Op[2] = 2'b00; r0A[2] = 32'(i); r0B[2] = 32'd1;
      #1;
      tick();
      r0Valid[2] = 1'b0;
      tick();
      checks++; if (respResult[2] !== 32'(i + 1)) begin errors++; $display("FAIL sat_result_%0d got %0d want %0d", i, respResult[2], i + 1); end
      tick();
      checks++; if (opCountC !== expCnt[i]) begin errors++; $display("FAIL sat_count_%0d got %0d want %0d", i, opCountC, expCnt[i]); end
    end
  endtask

  initial begin
    resetN = 1'b0;
    for (int d = 0; d < 3; d++) begin
      r0Valid[d] = 1'b0; r1Valid[d] = 1'b0; respReady[d] = 1'b0;
      r0Op[d] = 2'b00; r1Op[d] = 2'b00;
      r0A[d] = 32'd0; r0B[d] = 32'd0; r1A[d] = 32'd0; r1B[d] = 32'd0;
    end
    test_reset();
    test_single();
    test_round_robin();
    test_fixed_prio();
    test_stall();
    test_reset_exec();
    test_sat_count();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one instance of the team's 32-bit `alu` between two requesters (r0, r1).
- Each requester issues an ALU operation through a valid/ready request channel.
- The block arbitrates between them, registers the operands, runs the op through the ALU, and returns a registered result plus flags, tagged with the owning requester.
- Sits between the decode/issue logic and the shared ALU datapath. Also keeps a saturating count of completed operations.

Parameters:
- FIXED_PRIO, 0, arbitration mode. 0 = round-robin. 1 = r0 always wins a simultaneous request.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset_n  input  1  synchronous reset, active-low
- r0_valid  input  1  requester 0 has an operation
- r0_ready  output  1  requester 0 operation accepted this cycle
- r0_op  input  2  ALU control: 00 add, 01 xor, 10 sub, 11 slt
- r0_a  input  32  operand A
- r0_b  input  32  operand B
- r1_valid, r1_ready, r1_op, r1_a, r1_b  same as r0_* for requester 1
- resp_valid  output  1  response available
- resp_ready  input  1  consumer takes response
- resp_tag  output  1  requester that owns the response (0/1)
- resp_result  output  32  ALU Output
- resp_flags  output  4  {CarryOut, overflow, negative, zero}
- busy  output  1  high in any state except IDLE
- op_count  output  CNT_W  completed responses, saturating

Behaviour:
- Reset (reset_n low at a clock edge):
  - state=IDLE; resp_valid=0; resp_tag=0; resp_result=0; resp_flags=0; op_count=0; last_grant=1 (so r0 wins first).
  - An in-flight operation is discarded; no response is produced for it.
- State machine:
  - IDLE -> EXEC on acceptance.
  - EXEC -> RESP unconditionally.
  - RESP -> IDLE when resp_ready is high.
- Grant (combinational, IDLE only):
  - Only r0_valid high: grant r0. Only r1_valid high: grant r1.
  - Both high, FIXED_PRIO=1: grant r0.
  - Both high, FIXED_PRIO=0: grant the requester other than last_grant.
- rX_ready = (state==IDLE) && grant==X. Never asserted outside IDLE; at most one ready high per cycle.
- Acceptance happens when rX_valid && rX_ready. On that edge:
  - latch op/a/b into operand registers;
  - latch owner tag;
  - last_grant <= X.
- EXEC:
  - The ALU is driven only from the operand registers.
  - Output and flags are captured into resp_result/resp_flags at the end of EXEC.
  - resp_valid goes high entering RESP.
- Latency and throughput:
  - Accept at edge N; resp_valid high from cycle N+1 (after edge N+1).
  - Minimum 3 cycles per operation: IDLE, EXEC, RESP.
- Response hold:
  - resp_* are held stable while resp_valid=1 && resp_ready=0. Stall is unbounded.
  - New requests are not accepted during the stall.
- Response handshake:
  - resp_valid && resp_ready at an edge: resp_valid <= 0, state <= IDLE.
  - op_count increments by 1 unless it equals all-ones, in which case it holds.
  - The next acceptance can occur in the cycle after the return to IDLE.
- Requester rule (checked by bench):
  - Once valid is raised, it must stay high with stable op/a/b until ready.
  - A requester dropping valid in IDLE before grant is legal; nothing is latched.
- Flags:
  - Passed through from the ALU unmodified for all ops, including CarryOut/overflow for xor/slt.
  - slt result is 0 or 1.
- busy = (state != IDLE).

Test Plan:
- r0 only: op=00, a=0, b=1. Expect r0_ready in IDLE, resp_valid 1 cycle later, result=1, flags=0000, tag=0, op_count=1.
- Both valid, FIXED_PRIO=0, r0: sub 0-1, r1: slt 0<1. Expect:
  - r0 served first: result=FFFFFFFF, flags negative=1, overflow=0, zero=0, tag=0.
  - then r1: result=1, tag=1.
  - Third simultaneous request goes to r0 (alternation).
- FIXED_PRIO=1, both valid continuously for 3 ops. Expect r0 granted every time and r1_ready never high.
- r1: add 80000000+80000000, resp_ready held low 5 cycles. Expect:
  - result=0, flags=1101 (CarryOut, overflow, zero set; negative clear), held stable all 5 cycles.
  - r0_ready stays low throughout; completes on resp_ready.
- reset_n low during EXEC (r0: xor F0F0F0F0 ^ 0F0F0F0F). Expect:
  - next cycle IDLE, resp_valid=0, op_count=0, no response.
  - A re-issued request yields FFFFFFFF with negative=1.
- CNT_W=2: complete 5 ops. Expect op_count sequence 1, 2, 3, 3, 3.
